// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote, false-start rejection,
// parity/framing/break detection and a first-word-fall-through receive FIFO.
module uart_rx_ovs #(
   parameter int unsigned OVS        = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ck_en,
   input  logic                        rx_pin,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [DATA_BITS-1:0]        rd_data,
   output logic                        rd_perr,
   output logic                        rd_ferr,
   output logic                        rx_break,
   output logic                        overrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int unsigned PhW   = $clog2(OVS);
   localparam int unsigned Mid   = OVS / 2;
   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW  = AddrW + 1;
   localparam int unsigned WordW = DATA_BITS + 2;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

   state_e               state_q, state_d;
   logic [PhW-1:0]       ph_q, ph_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_q, par_d;
   logic                 ferr_q, ferr_d;
   logic                 zero_q, zero_d;
   logic                 va_q, va_d, vb_q, vb_d;
   logic                 s_last_q, s_last_d;
   logic                 rx_iob_q, rx_meta_q, s_q;
   logic                 rx_break_q, overrun_q;
   logic                 vote, perr, ferr_nx, zero_nx, push, brk;
   logic [WordW-1:0]     push_word, head;

   logic [WordW-1:0]     mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, level;
   logic                 full, pop, wr_en;

   // rx_iob_q is intended to be packed into the input pad register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_iob_q  <= 1'b1;
         rx_meta_q <= 1'b1;
         s_q       <= 1'b1;
      end else begin
         rx_iob_q  <= rx_pin;
         rx_meta_q <= rx_iob_q;
         s_q       <= rx_meta_q;
      end
   end

   assign vote    = (va_q & vb_q) | (va_q & s_q) | (vb_q & s_q);
   assign ferr_nx = ferr_q | ~vote;
   assign zero_nx = zero_q & ~vote;

   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      bit_d    = bit_q;
      data_d   = data_q;
      par_d    = par_q;
      ferr_d   = ferr_q;
      zero_d   = zero_q;
      va_d     = va_q;
      vb_d     = vb_q;
      s_last_d = s_last_q;
      push     = 1'b0;
      brk      = 1'b0;
      perr     = 1'b0;
      if (PARITY != 0) perr = (^data_q ^ par_q) != (PARITY == 1);
      if (ck_en) begin
         s_last_d = s_q;
         ph_d     = (ph_q == PhW'(OVS - 1)) ? '0 : ph_q + 1'b1;
         if (ph_q == PhW'(Mid - 1)) va_d = s_q;
         if (ph_q == PhW'(Mid)) vb_d = s_q;
         case (state_q)
            StIdle: begin
               if (s_last_q && !s_q) begin
                  state_d = StStart;
                  ph_d    = '0;
               end
            end
            StStart: begin
               if (ph_q == PhW'(Mid + 1)) begin
                  if (vote) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StData;
                     bit_d   = '0;
                     par_d   = 1'b0;
                  end
               end
            end
            StData: begin
               if (ph_q == PhW'(Mid + 1)) begin
                  data_d = {vote, data_q[DATA_BITS-1:1]};
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                     state_d = (PARITY != 0) ? StParity : StStop;
                     bit_d   = '0;
                     ferr_d  = 1'b0;
                     zero_d  = 1'b1;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
            end
            StParity: begin
               if (ph_q == PhW'(Mid + 1)) begin
                  par_d   = vote;
                  state_d = StStop;
               end
            end
            StStop: begin
               if (ph_q == PhW'(Mid + 1)) begin
                  ferr_d = ferr_nx;
                  zero_d = zero_nx;
                  if (bit_q == 4'(STOP_BITS - 1)) begin
                     // An all-zero frame with every stop bit low is a line break
                     if (data_q == '0 && (PARITY == 0 || !par_q) && zero_nx) begin
                        brk     = 1'b1;
                        state_d = StBreak;
                     end else begin
                        push    = 1'b1;
                        state_d = StIdle;
                     end
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
            end
            StBreak: begin
               if (s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         ph_q     <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         par_q    <= 1'b0;
         ferr_q   <= 1'b0;
         zero_q   <= 1'b0;
         va_q     <= 1'b1;
         vb_q     <= 1'b1;
         s_last_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         par_q    <= par_d;
         ferr_q   <= ferr_d;
         zero_q   <= zero_d;
         va_q     <= va_d;
         vb_q     <= vb_d;
         s_last_q <= s_last_d;
      end
   end

   assign push_word = {perr, ferr_nx, data_q};
   assign level     = wr_ptr_q - rd_ptr_q;
   assign full      = (level == PtrW'(FIFO_DEPTH));
   assign rd_valid  = (level != '0);
   assign pop       = rd_valid & rd_ready;
   // When full, a same-cycle pop frees the slot the write lands in
   assign wr_en     = push & (~full | pop);
   assign head      = mem_q[rd_ptr_q[AddrW-1:0]];

   assign {rd_perr, rd_ferr, rd_data} = rd_valid ? head : '0;
   assign fifo_level = level;
   assign rx_break   = rx_break_q;
   assign overrun    = overrun_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= push_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rx_break_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         rx_break_q <= brk;
         overrun_q  <= push & full & ~pop;
      end
   end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: two receiver configurations driven with random and
// directed frames, checked against a frame-level scoreboard of expected words.
module tb_uart_rx_ovs;
   localparam int unsigned OVS_A = 16, DB_A = 8, PAR_A = 0, SB_A = 1, D_A = 4;
   localparam int unsigned OVS_B = 8, DB_B = 7, PAR_B = 2, SB_B = 2, D_B = 2;

   logic clk = 1'b0, reset = 1'b1, ck_en = 1'b0;
   logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0;
   logic val_a, perr_a, ferr_a, brk_a, ovr_a;
   logic val_b, perr_b, ferr_b, brk_b, ovr_b;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic [2:0] lvl_a;
   logic [1:0] lvl_b;

   uart_rx_ovs #(.OVS(OVS_A), .DATA_BITS(DB_A), .PARITY(PAR_A), .STOP_BITS(SB_A),
                 .FIFO_DEPTH(D_A)) dut_a (
      .clk(clk), .reset(reset), .ck_en(ck_en), .rx_pin(rx_a), .rd_valid(val_a),
      .rd_ready(rdy_a), .rd_data(data_a), .rd_perr(perr_a), .rd_ferr(ferr_a),
      .rx_break(brk_a), .overrun(ovr_a), .fifo_level(lvl_a));

   uart_rx_ovs #(.OVS(OVS_B), .DATA_BITS(DB_B), .PARITY(PAR_B), .STOP_BITS(SB_B),
                 .FIFO_DEPTH(D_B)) dut_b (
      .clk(clk), .reset(reset), .ck_en(ck_en), .rx_pin(rx_b), .rd_valid(val_b),
      .rd_ready(rdy_b), .rd_data(data_b), .rd_perr(perr_b), .rd_ferr(ferr_b),
      .rx_break(brk_b), .overrun(ovr_b), .fifo_level(lvl_b));

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      ck_en = ~ck_en;
   end

   int n_cmp = 0, n_bad = 0;
   int mode_a = 2, mode_b = 2;  // 0 random ready, 1 ready low, 2 ready high
   int exp_brk[2], exp_ovr[2], brk_cnt[2], ovr_cnt[2], pops[2];
   logic [10:0] last_pop[2];
   logic [10:0] qa[$];
   logic [10:0] qb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      rdy_a = (mode_a == 0) ? ($urandom_range(0, 3) != 0) : (mode_a == 2);
      rdy_b = (mode_b == 0) ? ($urandom_range(0, 3) != 0) : (mode_b == 2);
   end

   task automatic scan(input int ln, input logic v, input logic r, input logic [8:0] d,
                       input logic pe, input logic fe);
      logic [10:0] act, expw;
      bit have;
      act = {pe, fe, d};
      if (v) begin
         have = (ln == 0) ? (qa.size() > 0) : (qb.size() > 0);
         if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL line%0d unexpected word: got 0x%0h, required none", ln, act);
         end else begin
            expw = (ln == 0) ? qa[0] : qb[0];
            check($sformatf("line%0d head word", ln), 32'(act), 32'(expw));
            if (r) begin
               if (ln == 0) void'(qa.pop_front());
               else void'(qb.pop_front());
               pops[ln]++;
               last_pop[ln] = act;
            end
         end
      end else begin
         check($sformatf("line%0d empty outputs", ln), 32'(act), 32'd0);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (brk_a) brk_cnt[0]++;
         if (brk_b) brk_cnt[1]++;
         if (ovr_a) ovr_cnt[0]++;
         if (ovr_b) ovr_cnt[1]++;
         scan(0, val_a, rdy_a, {1'b0, data_a}, perr_a, ferr_a);
         scan(1, val_b, rdy_b, {2'b0, data_b}, perr_b, ferr_b);
      end
   end

   // One tick lasts two clocks since ck_en toggles every falling edge
   task automatic drive(input int ln, input logic v, input int n);
      if (ln == 0) rx_a = v;
      else rx_b = v;
      repeat (2 * n) @(negedge clk);
   endtask

   // Builds one frame, records its expected outcome, then plays it tick by tick.
   // spike_at inverts one tick; cut_at >= 0 abandons the frame at that tick.
   task automatic send_frame(input int ln, input logic [8:0] data, input bit par_bad,
                             input logic [1:0] stops, input int spike_at, input int cut_at);
      int ovs, nb, pm, ns;
      logic bits[$];
      logic [8:0] dm;
      logic x, pb, perr, ferr, allz, lvl;
      ovs = (ln == 0) ? OVS_A : OVS_B;
      nb  = (ln == 0) ? DB_A : DB_B;
      pm  = (ln == 0) ? PAR_A : PAR_B;
      ns  = (ln == 0) ? SB_A : SB_B;
      dm = '0;
      x  = 1'b0;
      for (int i = 0; i < nb; i++) begin
         dm[i] = data[i];
         x     = x ^ data[i];
      end
      pb   = ((pm == 1) ? ~x : x) ^ par_bad;
      perr = (pm != 0) && par_bad;
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
      if (pm != 0) bits.push_back(pb);
      ferr = 1'b0;
      allz = 1'b1;
      for (int i = 0; i < ns; i++) begin
         bits.push_back(stops[i]);
         if (!stops[i]) ferr = 1'b1;
         else allz = 1'b0;
      end
      if (cut_at < 0) begin
         if (dm == '0 && (pm == 0 || !pb) && allz) begin
            exp_brk[ln]++;
         end else if (ln == 0) begin
            if (mode_a == 1 && qa.size() >= D_A) exp_ovr[0]++;
            else qa.push_back({perr, ferr, dm});
         end else begin
            if (mode_b == 1 && qb.size() >= D_B) exp_ovr[1]++;
            else qb.push_back({perr, ferr, dm});
         end
      end
      for (int t = 0; t < bits.size() * ovs; t++) begin
         if (cut_at >= 0 && t >= cut_at) return;
         lvl = bits[t / ovs];
         if (t == spike_at) lvl = ~lvl;
         drive(ln, lvl, 1);
      end
      drive(ln, 1'b1, 3 * ovs);
   endtask

   initial begin
      int p0, b0, o0;
      repeat (4) @(negedge clk);
      check("reset rd_valid A", 32'(val_a), 32'd0);
      check("reset level A", 32'(lvl_a), 32'd0);
      check("reset rd_data A", 32'(data_a), 32'd0);
      check("reset pulses", 32'({brk_a, ovr_a, brk_b, ovr_b}), 32'd0);
      check("reset rd_valid B", 32'(val_b), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      p0 = pops[0];
      send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, -1);
      check("A5 word", 32'(last_pop[0]), 32'h0A5);
      check("A5 count", 32'(pops[0] - p0), 32'd1);

      send_frame(1, 9'h03C, 1'b1, 2'b11, -1, -1);
      check("3C bad parity", 32'(last_pop[1]), 32'h43C);
      send_frame(1, 9'h03C, 1'b0, 2'b11, -1, -1);
      check("3C good parity", 32'(last_pop[1]), 32'h03C);

      send_frame(0, 9'h081, 1'b0, 2'b00, -1, -1);
      check("81 framing", 32'(last_pop[0]), 32'h281);
      send_frame(0, 9'h055, 1'b0, 2'b11, -1, -1);
      check("55 after ferr", 32'(last_pop[0]), 32'h055);

      b0 = brk_cnt[0];
      p0 = pops[0];
      exp_brk[0]++;
      drive(0, 1'b0, 12 * OVS_A);
      drive(0, 1'b1, 3 * OVS_A);
      check("break pulses", 32'(brk_cnt[0] - b0), 32'd1);
      check("break no push", 32'(pops[0] - p0), 32'd0);
      send_frame(0, 9'h055, 1'b0, 2'b11, -1, -1);
      check("55 after break", 32'(last_pop[0]), 32'h055);

      p0 = pops[0];
      drive(0, 1'b0, 4);
      drive(0, 1'b1, 3 * OVS_A);
      check("glitch no push", 32'(pops[0] - p0), 32'd0);
      check("glitch level", 32'(lvl_a), 32'd0);
      send_frame(0, 9'h000, 1'b0, 2'b11, 4 * OVS_A + OVS_A / 2, -1);
      check("spiked 00", 32'(last_pop[0]), 32'h000);
      check("spiked count", 32'(pops[0] - p0), 32'd1);

      mode_a = 0;
      mode_b = 0;
      for (int k = 0; k < 30; k++) begin
         logic [8:0] d;
         logic [1:0] st;
         int sp;
         d = 9'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) d = '0;
         st = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b11;
         sp = -1;
         if ($urandom_range(0, 1) == 1)
            sp = int'((1 + $urandom_range(0, 7)) * OVS_A + OVS_A / 2 - 1 + $urandom_range(0, 2));
         send_frame(0, d, 1'b0, st, sp, -1);
      end
      for (int k = 0; k < 40; k++) begin
         logic [8:0] d;
         logic [1:0] st;
         int sp;
         bit pbad;
         d = 9'($urandom_range(0, 127));
         if ($urandom_range(0, 9) == 0) d = '0;
         pbad = ($urandom_range(0, 3) == 0);
         st = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
         sp = -1;
         if ($urandom_range(0, 1) == 1)
            sp = int'((1 + $urandom_range(0, 6)) * OVS_B + OVS_B / 2 - 1 + $urandom_range(0, 2));
         send_frame(1, d, pbad, st, sp, -1);
      end

      mode_a = 2;
      mode_b = 2;
      repeat (20) @(negedge clk);
      mode_a = 1;
      repeat (4) @(negedge clk);
      o0 = ovr_cnt[0];
      p0 = pops[0];
      for (int k = 1; k <= 5; k++) begin
         send_frame(0, 9'(k), 1'b0, 2'b11, -1, -1);
         check($sformatf("level after word %0d", k), 32'(lvl_a), 32'(qa.size()));
      end
      check("full level", 32'(lvl_a), 32'd4);
      check("overrun pulses", 32'(ovr_cnt[0] - o0), 32'd1);
      mode_a = 2;
      repeat (20) @(negedge clk);
      check("drain count", 32'(pops[0] - p0), 32'd4);
      check("drain last", 32'(last_pop[0]), 32'h004);

      mode_a = 1;
      repeat (4) @(negedge clk);
      send_frame(0, 9'h011, 1'b0, 2'b11, -1, -1);
      check("pre-reset level", 32'(lvl_a), 32'd1);
      send_frame(0, 9'h022, 1'b0, 2'b11, -1, 5 * OVS_A);
      rx_a  = 1'b1;
      reset = 1'b1;
      qa.delete();
      qb.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post-reset level", 32'(lvl_a), 32'd0);
      check("post-reset rd_valid", 32'(val_a), 32'd0);
      mode_a = 2;
      send_frame(0, 9'h055, 1'b0, 2'b11, -1, -1);
      check("55 after reset", 32'(last_pop[0]), 32'h055);

      repeat (40) @(negedge clk);
      check("queue A drained", 32'(qa.size()), 32'd0);
      check("queue B drained", 32'(qb.size()), 32'd0);
      check("break total A", 32'(brk_cnt[0]), 32'(exp_brk[0]));
      check("break total B", 32'(brk_cnt[1]), 32'(exp_brk[1]));
      check("overrun total A", 32'(ovr_cnt[0]), 32'(exp_ovr[0]));
      check("overrun total B", 32'(ovr_cnt[1]), 32'(exp_ovr[1]));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
